// File: rtl/uart_cfg_pkg.sv
// Shared constants, FSM encoding and command legality check for the UART
// configuration register-file arbiter.
package uart_cfg_pkg;

   localparam logic [3:0] ADDR_DEFAULTS = 4'b0000;
   localparam logic [3:0] ADDR_PARITY   = 4'b1001;
   localparam logic [3:0] ADDR_PTYPE    = 4'b1010;
   localparam logic [3:0] ADDR_STOP     = 4'b1011;
   localparam logic [3:0] ADDR_FLEN     = 4'b1100;

   // The register file cannot tell a write of F from a read, so F is reserved.
   localparam logic [3:0] RD_CODE = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   function automatic logic cmd_legal(input logic       rd,
                                      input logic [3:0] addr,
                                      input logic [3:0] wdata);
      logic ok;
      case (addr)
         ADDR_DEFAULTS: ok = !rd && (wdata != RD_CODE);
         ADDR_PARITY, ADDR_PTYPE, ADDR_STOP, ADDR_FLEN:
                        ok = rd || (wdata != RD_CODE);
         default:       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-request round-robin picker. The pick is combinational; the last-grant
// pointer only moves when the sequencer accepts the pick.
module uart_rr_arb2 (
   input  logic       clk_16bd,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] pick
);

   logic last_q;
   logic last_d;

   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last_q ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
      last_d = last_q;
      if (accept)
         last_d = pick[1];
   end

   // Pointer resets to port 1 so port 0 wins the first contested grant.
   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst)
         last_q <= 1'b1;
      else
         last_q <= last_d;
   end

endmodule

// File: rtl/uart_cfg_arbiter.sv
// Arbitrates two requesters onto the UART config register file and sequences
// one valid/ack transaction at a time, returning read data or an error.
module uart_cfg_arbiter
   import uart_cfg_pkg::*;
#(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk_16bd,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       rd0,
   input  logic       rd1,
   input  logic [3:0] addr0,
   input  logic [3:0] addr1,
   input  logic [3:0] wdata0,
   input  logic [3:0] wdata1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       done0,
   output logic       done1,
   output logic [3:0] rdata,
   output logic       err,
   output logic       busy,
   output logic       rf_valid,
   output logic [3:0] rf_address,
   output logic [3:0] rf_data,
   input  logic       rf_ack,
   input  logic       rf_data_out_valid,
   input  logic [3:0] rf_data_out
);

   localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       rd_q, rd_d;
   logic [3:0] cnt_q, cnt_d;
   logic       gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic       done0_q, done0_d, done1_q, done1_d;
   logic [3:0] rdata_q, rdata_d;
   logic       err_q, err_d;
   logic       busy_q, busy_d;
   logic       rf_valid_q, rf_valid_d;
   logic [3:0] rf_address_q, rf_address_d;
   logic [3:0] rf_data_q, rf_data_d;

   logic [1:0] pick;
   logic       accept;
   logic       win;
   logic       cmd_rd;
   logic [3:0] cmd_addr;
   logic [3:0] cmd_wdata;

   assign accept    = (state_q == ST_IDLE) && (|pick);
   assign win       = pick[1];
   assign cmd_rd    = win ? rd1    : rd0;
   assign cmd_addr  = win ? addr1  : addr0;
   assign cmd_wdata = win ? wdata1 : wdata0;

   uart_rr_arb2 u_arb (
      .clk_16bd (clk_16bd),
      .rst      (rst),
      .req      ({req1, req0}),
      .accept   (accept),
      .pick     (pick)
   );

   always_comb begin
      state_d      = state_q;
      rd_d         = rd_q;
      cnt_d        = cnt_q;
      gnt0_d       = gnt0_q;
      gnt1_d       = gnt1_q;
      done0_d      = 1'b0;
      done1_d      = 1'b0;
      rdata_d      = rdata_q;
      err_d        = err_q;
      rf_valid_d   = 1'b0;
      rf_address_d = rf_address_q;
      rf_data_d    = rf_data_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_d   = cmd_rd;
               gnt0_d = !win;
               gnt1_d = win;
               if (cmd_legal(cmd_rd, cmd_addr, cmd_wdata)) begin
                  state_d      = ST_ISSUE;
                  rf_valid_d   = 1'b1;
                  rf_address_d = cmd_addr;
                  rf_data_d    = cmd_rd ? RD_CODE : cmd_wdata;
               end else begin
                  // Illegal commands never reach the register file.
                  state_d = ST_RESP;
                  err_d   = 1'b1;
                  rdata_d = 4'h0;
                  done0_d = !win;
                  done1_d = win;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = 4'h0;
         end
         ST_WAIT: begin
            if (rf_ack) begin
               state_d = ST_RESP;
               rdata_d = (rd_q && rf_data_out_valid) ? rf_data_out : 4'h0;
               err_d   = 1'b0;
               done0_d = gnt0_q;
               done1_d = gnt1_q;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_RESP;
               rdata_d = 4'h0;
               err_d   = 1'b1;
               done0_d = gnt0_q;
               done1_d = gnt1_q;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_16bd or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rd_q         <= 1'b0;
         cnt_q        <= 4'h0;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         done0_q      <= 1'b0;
         done1_q      <= 1'b0;
         rdata_q      <= 4'h0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
         rf_valid_q   <= 1'b0;
         rf_address_q <= 4'h0;
         rf_data_q    <= 4'h0;
      end else begin
         state_q      <= state_d;
         rd_q         <= rd_d;
         cnt_q        <= cnt_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         done0_q      <= done0_d;
         done1_q      <= done1_d;
         rdata_q      <= rdata_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
         rf_valid_q   <= rf_valid_d;
         rf_address_q <= rf_address_d;
         rf_data_q    <= rf_data_d;
      end
   end

   assign gnt0       = gnt0_q;
   assign gnt1       = gnt1_q;
   assign done0      = done0_q;
   assign done1      = done1_q;
   assign rdata      = rdata_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign rf_valid   = rf_valid_q;
   assign rf_address = rf_address_q;
   assign rf_data    = rf_data_q;

endmodule
